// File: rtl/ram_weight_loader.sv
// Streams a weight block from the weight RAM and demuxes it to NUM_UNITS neuron-unit write ports.
// Latency: first write RD_LAT+2 cycles after the start edge; writes back-to-back; done one cycle after the last write.
// No backpressure: reads issue every cycle once started; abort flushes in-flight reads.
module ram_weight_loader #(
  parameter int  DATA_W    = 8,
  parameter int  NUM_UNITS = 4,
  parameter int  WPU       = 16,
  parameter int  ADDR_W    = 8,
  parameter int  RD_LAT    = 1,
  localparam int IDX_W     = (WPU > 1) ? $clog2(WPU) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        bcast,
  input  logic                        abort,
  input  logic [ADDR_W-1:0]           base_addr,
  output logic                        ram_rd_en,
  output logic [ADDR_W-1:0]           ram_addr,
  input  logic [DATA_W-1:0]           ram_data,
  output logic [NUM_UNITS*DATA_W-1:0] weight_bus,
  output logic [NUM_UNITS-1:0]        write,
  output logic [IDX_W-1:0]            weight_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int UNIT_W = $clog2(NUM_UNITS);
  localparam int CNT_W  = $clog2(NUM_UNITS * WPU + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           base_q, base_d;
  logic                        bcast_q, bcast_d;
  logic [CNT_W-1:0]            total_q, total_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  // unit/idx of the next read to issue
  logic [UNIT_W-1:0]           unit_q, unit_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  // tag of the read currently on the RAM port
  logic [UNIT_W-1:0]           tag_unit_q, tag_unit_d;
  logic [IDX_W-1:0]            tag_idx_q, tag_idx_d;
  // read-valid pipeline; the last stage lines up with valid ram_data
  logic [RD_LAT-1:0]           vld_q, vld_d;
  logic [UNIT_W-1:0]           pipe_unit_q [RD_LAT];
  logic [UNIT_W-1:0]           pipe_unit_d [RD_LAT];
  logic [IDX_W-1:0]            pipe_idx_q  [RD_LAT];
  logic [IDX_W-1:0]            pipe_idx_d  [RD_LAT];
  logic [NUM_UNITS*DATA_W-1:0] bus_q, bus_d;
  logic [NUM_UNITS-1:0]        wr_q, wr_d;
  logic [IDX_W-1:0]            widx_q, widx_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        kill;

  // abort only matters while a load is in flight
  assign kill = abort && ((state_q == READ) || (state_q == DRAIN));

  // FSM next state, read issue and status flags
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    bcast_d    = bcast_q;
    total_d    = total_q;
    cnt_d      = cnt_q;
    unit_d     = unit_q;
    idx_d      = idx_q;
    rd_en_d    = 1'b0;
    addr_d     = addr_q;
    tag_unit_d = tag_unit_q;
    tag_idx_d  = tag_idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          bcast_d = bcast;
          total_d = bcast ? CNT_W'(WPU) : CNT_W'(NUM_UNITS * WPU);
          cnt_d   = '0;
          unit_d  = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        rd_en_d    = 1'b1;
        addr_d     = base_q + ADDR_W'(cnt_q);
        tag_unit_d = unit_q;
        tag_idx_d  = idx_q;
        cnt_d      = cnt_q + CNT_W'(1);
        if (idx_q == IDX_W'(WPU - 1)) begin
          idx_d  = '0;
          unit_d = unit_q + UNIT_W'(1);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
        if (cnt_q == total_q - CNT_W'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        // last read has left the RAM port and the pipeline is empty
        if (!rd_en_q && (vld_q == '0)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) begin
      state_d = IDLE;
      rd_en_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // read-valid shift register and demux of the emerging word onto the unit buses
  always_comb begin
    vld_d          = '0;
    vld_d[0]       = rd_en_q;
    pipe_unit_d[0] = tag_unit_q;
    pipe_idx_d[0]  = tag_idx_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]       = vld_q[i-1];
      pipe_unit_d[i] = pipe_unit_q[i-1];
      pipe_idx_d[i]  = pipe_idx_q[i-1];
    end
    if (kill) vld_d = '0;

    wr_d   = '0;
    bus_d  = '0;
    widx_d = '0;
    if (vld_q[RD_LAT-1] && !kill) begin
      widx_d = pipe_idx_q[RD_LAT-1];
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (bcast_q || (pipe_unit_q[RD_LAT-1] == UNIT_W'(u))) begin
          wr_d[u]                    = 1'b1;
          bus_d[u*DATA_W +: DATA_W] = ram_data;
        end
      end
    end
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      bcast_q     <= 1'b0;
      total_q     <= '0;
      cnt_q       <= '0;
      unit_q      <= '0;
      idx_q       <= '0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      tag_unit_q  <= '0;
      tag_idx_q   <= '0;
      vld_q       <= '0;
      pipe_unit_q <= '{default: '0};
      pipe_idx_q  <= '{default: '0};
      bus_q       <= '0;
      wr_q        <= '0;
      widx_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      bcast_q     <= bcast_d;
      total_q     <= total_d;
      cnt_q       <= cnt_d;
      unit_q      <= unit_d;
      idx_q       <= idx_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      tag_unit_q  <= tag_unit_d;
      tag_idx_q   <= tag_idx_d;
      vld_q       <= vld_d;
      pipe_unit_q <= pipe_unit_d;
      pipe_idx_q  <= pipe_idx_d;
      bus_q       <= bus_d;
      wr_q        <= wr_d;
      widx_q      <= widx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ram_rd_en  = rd_en_q;
  assign ram_addr   = addr_q;
  assign weight_bus = bus_q;
  assign write      = wr_q;
  assign weight_idx = widx_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ram_weight_loader.sv
// Bench for ram_weight_loader: two instances (RD_LAT=1 and RD_LAT=3) share stimulus.
// Each has its own RAM model with RAM[a] = a + 0x10; outputs are logged on the falling edge.
// Directed load vectors from a table plus hand-written reset/abort sequences.
module tb_ram_weight_loader;

  typedef struct {int cyc; logic [7:0] addr;} rd_t;
  typedef struct {int cyc; logic [3:0] w; logic [31:0] bus; logic [1:0] idx;} wr_t;
  typedef struct {logic [7:0] base; logic bc; int mid_start; int total;} vec_t;

  logic        clk = 1'b0;
  logic        rst_n, start, bcast, abort;
  logic [7:0]  base_addr;
  logic        rd_en1, rd_en3, busy1, busy3, done1, done3;
  logic [7:0]  addr1, addr3, data1, data3, p3a, p3b;
  logic [31:0] bus1, bus3;
  logic [3:0]  wr_o1, wr_o3;
  logic [1:0]  idx1, idx3;

  int  cyc = 0;
  int  nchecks = 0;
  int  nerr = 0;
  rd_t rdq[$];
  wr_t wq1[$];
  wr_t wq3[$];
  int  dq1[$];
  int  dq3[$];
  vec_t vecs[3];

  always #5 clk = ~clk;

  ram_weight_loader #(.DATA_W(8), .NUM_UNITS(4), .WPU(4), .ADDR_W(8), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .bcast(bcast), .abort(abort),
    .base_addr(base_addr), .ram_rd_en(rd_en1), .ram_addr(addr1), .ram_data(data1),
    .weight_bus(bus1), .write(wr_o1), .weight_idx(idx1), .busy(busy1), .done(done1));

  ram_weight_loader #(.DATA_W(8), .NUM_UNITS(4), .WPU(4), .ADDR_W(8), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .bcast(bcast), .abort(abort),
    .base_addr(base_addr), .ram_rd_en(rd_en3), .ram_addr(addr3), .ram_data(data3),
    .weight_bus(bus3), .write(wr_o3), .weight_idx(idx3), .busy(busy3), .done(done3));

  // cycle counter and RAM models (1-cycle and 3-cycle read latency)
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    data1 <= addr1 + 8'h10;
    p3a   <= addr3 + 8'h10;
    p3b   <= p3a;
    data3 <= p3b;
  end

  // output logging away from the active edge
  always @(negedge clk) begin
    if (rd_en1 === 1'b1) rdq.push_back(rd_t'{cyc, addr1});
    if (wr_o1 != 4'h0) wq1.push_back(wr_t'{cyc, wr_o1, bus1, idx1});
    if (wr_o3 != 4'h0) wq3.push_back(wr_t'{cyc, wr_o3, bus3, idx3});
    if (done1 === 1'b1) dq1.push_back(cyc);
    if (done3 === 1'b1) dq3.push_back(cyc);
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_logs();
    rdq.delete(); wq1.delete(); wq3.delete(); dq1.delete(); dq3.delete();
  endtask

  // pulse start, return the cycle number of the accepting edge
  task automatic do_start(input logic [7:0] b, input logic bc, output int s);
    @(posedge clk); #1;
    base_addr = b; bcast = bc; start = 1'b1;
    @(posedge clk); #1;
    s = cyc; start = 1'b0;
    clear_logs();
  endtask

  task automatic check_writes(input int lat, input int s, input logic [7:0] b, input logic bc, input int total);
    wr_t wq[$];
    int  dq[$];
    if (lat == 1) begin wq = wq1; dq = dq1; end
    else begin wq = wq3; dq = dq3; end
    check($sformatf("lat%0d_nwr", lat), wq.size(), total);
    for (int k = 0; k < wq.size() && k < total; k++) begin
      logic [7:0]  d;
      logic [3:0]  ew;
      logic [31:0] eb;
      logic [1:0]  ei;
      d = b + 8'(k) + 8'h10;
      if (bc) begin
        ew = 4'hF; eb = {4{d}}; ei = 2'(k);
      end else begin
        ew = 4'(1 << (k / 4)); eb = 32'(d) << (8 * (k / 4)); ei = 2'(k % 4);
      end
      check($sformatf("lat%0d_wr%0d {cyc,w,bus,idx}", lat, k),
            {32'(wq[k].cyc), wq[k].w, wq[k].bus, wq[k].idx},
            {32'(s + lat + 2 + k), ew, eb, ei});
    end
    check($sformatf("lat%0d_ndone", lat), dq.size(), 1);
    if (dq.size() > 0) check($sformatf("lat%0d_done_cyc", lat), dq[0], s + lat + 2 + total);
  endtask

  task automatic run_load(input logic [7:0] b, input logic bc, input int mid, input int total);
    int s;
    do_start(b, bc, s);
    check("busy_after_start", {busy1, busy3}, 2'b11);
    for (int c = 1; c <= 30; c++) begin
      start = (c == mid);
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("nrd", rdq.size(), total);
    for (int k = 0; k < rdq.size() && k < total; k++) begin
      logic [7:0] ea;
      ea = b + 8'(k);
      check($sformatf("rd%0d {cyc,addr}", k), {32'(rdq[k].cyc), rdq[k].addr}, {32'(s + 1 + k), ea});
    end
    check_writes(1, s, b, bc, total);
    check_writes(3, s, b, bc, total);
    check("busy_idle", {busy1, busy3}, 2'b00);
  endtask

  initial begin
    int s;
    vecs[0] = '{8'h20, 1'b0, 0, 16};
    vecs[1] = '{8'h40, 1'b1, 0, 4};
    vecs[2] = '{8'hFC, 1'b0, 7, 16};

    // reset held with start asserted: outputs stay zero, no reads
    rst_n = 1'b0; start = 1'b1; bcast = 1'b0; abort = 1'b0; base_addr = 8'h20;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("rst_out%0d", i), {rd_en1, addr1, bus1, wr_o1, idx1, busy1, done1,
             rd_en3, addr3, bus3, wr_o3, idx3, busy3, done3}, 0);
    end
    rst_n = 1'b1; start = 1'b0;
    clear_logs();
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_reads", rdq.size(), 0);
    check("rst_idle", {busy1, done1, wr_o1}, 0);

    // table-driven loads: normal, broadcast, address wrap with ignored mid-load start
    for (int v = 0; v < 3; v++)
      run_load(vecs[v].base, vecs[v].bc, vecs[v].mid_start, vecs[v].total);

    // abort during the 6th read of a normal load
    do_start(8'h20, 1'b0, s);
    repeat (6) @(posedge clk);
    #1;
    check("abort_6th_rd", {rd_en1, addr1}, {1'b1, 8'h25});
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_next", {busy1, done1, rd_en1, wr_o1, busy3, done3, rd_en3, wr_o3}, 0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_nwr1", wq1.size(), 4);
    check("abort_nwr3", wq3.size(), 2);
    check("abort_last_wr1", (wq1.size() > 0) ? wq1[wq1.size()-1].cyc : 0, s + 6);
    check("abort_no_done", dq1.size() + dq3.size(), 0);
    check("abort_nrd", rdq.size(), 6);
    run_load(8'h20, 1'b0, 0, 16);

    // reset in the middle of a load
    do_start(8'h20, 1'b0, s);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_out", {rd_en1, addr1, bus1, wr_o1, idx1, busy1, done1,
           rd_en3, addr3, bus3, wr_o3, idx3, busy3, done3}, 0);
    rst_n = 1'b1;
    clear_logs();
    repeat (12) @(posedge clk);
    #1;
    check("midrst_quiet", {32'(rdq.size()), 32'(wq1.size()), 32'(wq3.size()), 32'(dq1.size())}, 0);
    run_load(8'h40, 1'b1, 0, 4);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
